mem_boot_ctrl: RTL and testbench

Hardware boot sequencer for the CPU core. It streams an initial image from a 64-bit valid/ready source into data memory and instruction memory through the core's external memory ports, then asserts the core enable. It counts run cycles, detects the STOP instruction, and optionally streams a data-memory result window back out. It sits between the board-level loader (UART/JTAG bridge) and the `cpu` top, replacing bench-driven preload.

---
 rtl/mem_boot_ctrl_pkg.sv | 28 ++
 rtl/boot_word_cnt.sv | 39 +++
 rtl/mem_boot_ctrl.sv | 260 ++++++++++++++++++++++++++
 tb/tb_mem_boot_ctrl.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_boot_ctrl_pkg.sv
// Shared types and constants for the mem_boot_ctrl boot sequencer.
package mem_boot_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_D,
    S_LOAD_I,
    S_RUN,
    S_DUMP_RD,
    S_DUMP_OUT,
    S_DONE
  } boot_state_e;

  localparam int unsigned ADDR_W   = 64;
  localparam int unsigned STREAM_W = 64;
  localparam int unsigned DMEM_W   = 64;
  localparam int unsigned IMEM_W   = 32;
  localparam int unsigned COUNT_W  = 32;

  localparam logic [6:0]  STOP_OPCODE = 7'b1111110;
  localparam int unsigned STOP_ID_MSB = 31;
  localparam int unsigned STOP_ID_LSB = 28;

  function automatic logic is_stop(input logic [6:0] opcode);
    return opcode == STOP_OPCODE;
  endfunction

endpackage

// File: rtl/boot_word_cnt.sv
// Loadable up-counter with a terminal-count flag against a run-time limit.
module boot_word_cnt
  import mem_boot_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             arst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             inc,
  input  logic [WIDTH-1:0] last,
  output logic [WIDTH-1:0] count,
  output logic             tc
);

  logic [WIDTH-1:0] count_d, count_q;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (inc) begin
      count_d = count_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;
  assign tc    = (count_q == last);

endmodule

// File: rtl/mem_boot_ctrl.sv
// Boot sequencer: streams dmem/imem image, runs the core until STOP,
// optionally reads back a dmem window (MEM_BOOT_CTRL_READBACK_EN).
module mem_boot_ctrl
  import mem_boot_ctrl_pkg::*;
#(
  parameter int unsigned IMEM_WORDS = 512,
  parameter int unsigned DMEM_WORDS = 1024,
  parameter int unsigned DUMP_BASE  = 35,
  parameter int unsigned DUMP_LEN   = 12
) (
  input  logic                clk,
  input  logic                arst,
  input  logic                start,
  input  logic                s_valid,
  input  logic [STREAM_W-1:0] s_data,
  output logic                s_ready,
  output logic [ADDR_W-1:0]   addr_ext,
  output logic                wen_ext,
  output logic                ren_ext,
  output logic [IMEM_W-1:0]   wdata_ext,
  output logic [ADDR_W-1:0]   addr_ext_2,
  output logic                wen_ext_2,
  output logic                ren_ext_2,
  output logic [DMEM_W-1:0]   wdata_ext_2,
  input  logic [DMEM_W-1:0]   rdata_ext_2,
  input  logic [31:0]         instr,
  output logic                cpu_enable,
  output logic                m_valid,
  output logic [DMEM_W-1:0]   m_data,
  input  logic                m_ready,
  output logic [3:0]          stop_id,
  output logic [COUNT_W-1:0]  cycle_count,
  output logic                done
);

  localparam int unsigned MAX_WORDS = (DMEM_WORDS > IMEM_WORDS) ? DMEM_WORDS : IMEM_WORDS;
  localparam int unsigned CNT_W     = $clog2(MAX_WORDS + 1);
  localparam logic [CNT_W-1:0] D_LAST = CNT_W'(DMEM_WORDS - 1);
  localparam logic [CNT_W-1:0] I_LAST = CNT_W'(IMEM_WORDS - 1);

  boot_state_e        state_d, state_q;
  logic [CNT_W-1:0]   cnt, cnt_last;
  logic               cnt_tc, cnt_load, cnt_inc;
  logic               beat, stop_hit;
  logic               wen_d, wen_q, wen2_d, wen2_q, cpu_en_d, cpu_en_q;
  logic [ADDR_W-1:0]  addr_d, addr_q, addr2_d, addr2_q;
  logic [IMEM_W-1:0]  wdata_d, wdata_q;
  logic [DMEM_W-1:0]  wdata2_d, wdata2_q;
  logic [COUNT_W-1:0] cyc_d, cyc_q;
  logic [3:0]         stop_id_d, stop_id_q;

`ifdef MEM_BOOT_CTRL_READBACK_EN
  localparam int unsigned K_W = $clog2(DUMP_LEN + 1);
  localparam logic [K_W-1:0] K_LAST = K_W'(DUMP_LEN - 1);

  logic [K_W-1:0]    k;
  logic              k_tc, k_load, k_inc;
  logic              ren2_d, ren2_q, m_valid_d, m_valid_q;
  logic [DMEM_W-1:0] m_data_d, m_data_q;

  boot_word_cnt #(.WIDTH(K_W)) u_k_cnt (
    .clk      (clk),
    .arst     (arst),
    .load     (k_load),
    .load_val ('0),
    .inc      (k_inc),
    .last     (K_LAST),
    .count    (k),
    .tc       (k_tc)
  );
`endif

  assign cnt_last = (state_q == S_LOAD_D) ? D_LAST : I_LAST;

  boot_word_cnt #(.WIDTH(CNT_W)) u_word_cnt (
    .clk      (clk),
    .arst     (arst),
    .load     (cnt_load),
    .load_val ('0),
    .inc      (cnt_inc),
    .last     (cnt_last),
    .count    (cnt),
    .tc       (cnt_tc)
  );

  assign s_ready  = (state_q == S_LOAD_D) || (state_q == S_LOAD_I);
  assign beat     = s_valid && s_ready;
  // STOP only counts once the core is actually enabled, never in the RUN entry cycle.
  assign stop_hit = cpu_en_q && is_stop(instr[6:0]);

  always_comb begin
    state_d   = state_q;
    cnt_load  = 1'b0;
    cnt_inc   = 1'b0;
    wen_d     = 1'b0;
    wen2_d    = 1'b0;
    addr_d    = addr_q;
    addr2_d   = addr2_q;
    wdata_d   = wdata_q;
    wdata2_d  = wdata2_q;
    cpu_en_d  = 1'b0;
    cyc_d     = cyc_q;
    stop_id_d = stop_id_q;
`ifdef MEM_BOOT_CTRL_READBACK_EN
    k_load    = 1'b0;
    k_inc     = 1'b0;
    ren2_d    = 1'b0;
    m_valid_d = m_valid_q;
    m_data_d  = m_data_q;
`endif
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d   = S_LOAD_D;
          cnt_load  = 1'b1;
          cyc_d     = '0;
          stop_id_d = '0;
        end
      end
      S_LOAD_D: begin
        if (beat) begin
          wen2_d   = 1'b1;
          addr2_d  = ADDR_W'(cnt) << 3;
          wdata2_d = s_data;
          if (cnt_tc) begin
            cnt_load = 1'b1;
            state_d  = S_LOAD_I;
          end else begin
            cnt_inc = 1'b1;
          end
        end
      end
      S_LOAD_I: begin
        if (beat) begin
          wen_d   = 1'b1;
          addr_d  = ADDR_W'(cnt) << 2;
          wdata_d = s_data[IMEM_W-1:0];
          if (cnt_tc) begin
            cnt_load = 1'b1;
            state_d  = S_RUN;
          end else begin
            cnt_inc = 1'b1;
          end
        end
      end
      S_RUN: begin
        cpu_en_d = 1'b1;
        if (cpu_en_q) begin
          if (cyc_q != '1) begin
            cyc_d = cyc_q + COUNT_W'(1);
          end
          if (stop_hit) begin
            cpu_en_d  = 1'b0;
            stop_id_d = instr[STOP_ID_MSB:STOP_ID_LSB];
`ifdef MEM_BOOT_CTRL_READBACK_EN
            state_d   = S_DUMP_RD;
            k_load    = 1'b1;
            ren2_d    = 1'b1;
            addr2_d   = ADDR_W'(DUMP_BASE) << 3;
`else
            state_d   = S_DONE;
`endif
          end
        end
      end
`ifdef MEM_BOOT_CTRL_READBACK_EN
      S_DUMP_RD: begin
        state_d = S_DUMP_OUT;
      end
      S_DUMP_OUT: begin
        // First DUMP_OUT cycle captures the read data; later cycles wait for the handshake.
        if (!m_valid_q) begin
          m_data_d  = rdata_ext_2;
          m_valid_d = 1'b1;
        end else if (m_ready) begin
          m_valid_d = 1'b0;
          if (k_tc) begin
            state_d = S_DONE;
          end else begin
            k_inc   = 1'b1;
            ren2_d  = 1'b1;
            addr2_d = (ADDR_W'(DUMP_BASE) + ADDR_W'(k) + ADDR_W'(1)) << 3;
            state_d = S_DUMP_RD;
          end
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state_q   <= S_IDLE;
      wen_q     <= 1'b0;
      wen2_q    <= 1'b0;
      addr_q    <= '0;
      addr2_q   <= '0;
      wdata_q   <= '0;
      wdata2_q  <= '0;
      cpu_en_q  <= 1'b0;
      cyc_q     <= '0;
      stop_id_q <= '0;
    end else begin
      state_q   <= state_d;
      wen_q     <= wen_d;
      wen2_q    <= wen2_d;
      addr_q    <= addr_d;
      addr2_q   <= addr2_d;
      wdata_q   <= wdata_d;
      wdata2_q  <= wdata2_d;
      cpu_en_q  <= cpu_en_d;
      cyc_q     <= cyc_d;
      stop_id_q <= stop_id_d;
    end
  end

`ifdef MEM_BOOT_CTRL_READBACK_EN
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      ren2_q    <= 1'b0;
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
    end else begin
      ren2_q    <= ren2_d;
      m_valid_q <= m_valid_d;
      m_data_q  <= m_data_d;
    end
  end

  assign ren_ext_2 = ren2_q;
  assign m_valid   = m_valid_q;
  assign m_data    = m_data_q;

  logic unused_ok;
  assign unused_ok = ^instr[STOP_ID_LSB-1:7];
`else
  assign ren_ext_2 = 1'b0;
  assign m_valid   = 1'b0;
  assign m_data    = '0;

  logic        unused_ok;
  logic [31:0] unused_dump;
  assign unused_ok   = ^{instr[STOP_ID_LSB-1:7], m_ready, rdata_ext_2};
  assign unused_dump = DUMP_BASE ^ DUMP_LEN;
`endif

  assign addr_ext    = addr_q;
  assign wen_ext     = wen_q;
  assign ren_ext     = 1'b0;
  assign wdata_ext   = wdata_q;
  assign addr_ext_2  = addr2_q;
  assign wen_ext_2   = wen2_q;
  assign wdata_ext_2 = wdata2_q;
  assign cpu_enable  = cpu_en_q;
  assign stop_id     = stop_id_q;
  assign cycle_count = cyc_q;
  assign done        = (state_q == S_DONE);

endmodule

// File: tb/tb_mem_boot_ctrl.sv
// Directed bench for mem_boot_ctrl: image load, run/STOP, readback, async reset.
module tb_mem_boot_ctrl;

  localparam int unsigned IW = 512;
  localparam int unsigned DW = 1024;
  localparam int unsigned NB = IW + DW;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        arst = 1'b0;
  logic        start = 1'b0;
  logic        s_valid = 1'b0;
  logic [63:0] s_data = '0;
  logic        s_ready;
  logic [63:0] addr_ext, addr_ext_2;
  logic        wen_ext, ren_ext, wen_ext_2, ren_ext_2;
  logic [31:0] wdata_ext;
  logic [63:0] wdata_ext_2, rdata_ext_2;
  logic [31:0] instr = NOP;
  logic        cpu_enable;
  logic        m_valid;
  logic [63:0] m_data;
  logic        m_ready = 1'b0;
  logic [3:0]  stop_id;
  logic [31:0] cycle_count;
  logic        done;

  mem_boot_ctrl #(
    .IMEM_WORDS (IW),
    .DMEM_WORDS (DW),
    .DUMP_BASE  (35),
    .DUMP_LEN   (12)
  ) dut (
    .clk         (clk),
    .arst        (arst),
    .start       (start),
    .s_valid     (s_valid),
    .s_data      (s_data),
    .s_ready     (s_ready),
    .addr_ext    (addr_ext),
    .wen_ext     (wen_ext),
    .ren_ext     (ren_ext),
    .wdata_ext   (wdata_ext),
    .addr_ext_2  (addr_ext_2),
    .wen_ext_2   (wen_ext_2),
    .ren_ext_2   (ren_ext_2),
    .wdata_ext_2 (wdata_ext_2),
    .rdata_ext_2 (rdata_ext_2),
    .instr       (instr),
    .cpu_enable  (cpu_enable),
    .m_valid     (m_valid),
    .m_data      (m_data),
    .m_ready     (m_ready),
    .stop_id     (stop_id),
    .cycle_count (cycle_count),
    .done        (done)
  );

  always #5 clk = ~clk;

  // dmem with one-cycle read latency
  logic [63:0] dmem [DW];
  logic [63:0] rd_q = '0;
  always @(posedge clk) begin
    if (wen_ext_2) dmem[addr_ext_2[12:3]] <= wdata_ext_2;
    if (ren_ext_2) rd_q <= dmem[addr_ext_2[12:3]];
  end
  assign rdata_ext_2 = rd_q;

  typedef struct {
    int unsigned div;
    int unsigned n;
    logic [31:0] stop_instr;
    logic [3:0]  id;
    bit          pulse;
  } run_vec_t;

  run_vec_t    vecs [3];
  int          checks = 0;
  int          failures = 0;
  int unsigned cyc = 0, d_idx = 0, i_idx = 0;
  int unsigned t_last_i = 0, t_en = 0, t_last_d = 0, t_first_i = 0;
  logic [63:0] last_d = '0, last_i = '0;
  bit          en_prev = 1'b0;

  function automatic logic [63:0] dpat(input int unsigned i);
    if (i >= 35 && i <= 46) return 64'(600 - 45 * (i - 35));
    return {32'hD00D_0000, i};
  endfunction

  function automatic logic [63:0] ipat(input int unsigned i);
    return {32'hBAD0_0000 | i, 32'h1000_0000 | i};
  endfunction

  function automatic logic [63:0] beat_data(input int unsigned b);
    return (b < DW) ? dpat(b) : ipat(b - DW);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Every wait goes through here so write traffic is checked on each negedge.
  task automatic tick();
    logic [63:0] e;
    @(negedge clk);
    cyc++;
    if (wen_ext_2) begin
      chk("dwr_excl", {62'd0, wen_ext, ren_ext_2}, 64'd0);
      chk("dwr_addr", addr_ext_2, 64'(d_idx) << 3);
      chk("dwr_data", wdata_ext_2, dpat(d_idx));
      last_d   = addr_ext_2;
      t_last_d = cyc;
      d_idx++;
    end
    if (wen_ext) begin
      e = ipat(i_idx);
      chk("iwr_addr", addr_ext, 64'(i_idx) << 2);
      chk("iwr_data", 64'(wdata_ext), 64'(e[31:0]));
      if (i_idx == 0) t_first_i = cyc;
      last_i   = addr_ext;
      t_last_i = cyc;
      i_idx++;
    end
    if (cpu_enable && !en_prev) t_en = cyc;
    en_prev = cpu_enable;
  endtask

  task automatic rst_checks();
    chk("rst_ctrl", {56'd0, s_ready, wen_ext, ren_ext, wen_ext_2, ren_ext_2, cpu_enable, m_valid, done}, 64'd0);
    chk("rst_addr", addr_ext, 64'd0);
    chk("rst_addr2", addr_ext_2, 64'd0);
    chk("rst_wdata", 64'(wdata_ext), 64'd0);
    chk("rst_wdata2", wdata_ext_2, 64'd0);
    chk("rst_mdata", m_data, 64'd0);
    chk("rst_stop_id", 64'(stop_id), 64'd0);
    chk("rst_cycles", 64'(cycle_count), 64'd0);
  endtask

  task automatic load_image(input int unsigned div, input int unsigned abort_at);
    int unsigned beat = 0, ph = 0, guard = 0;
    d_idx = 0; i_idx = 0; t_en = 0; t_last_i = 0; t_last_d = 0; t_first_i = 0;
    start = 1'b1;
    while (beat < abort_at && guard < 6 * NB) begin
      tick();
      start   = 1'b0;
      s_valid = (ph % div) == 0;
      ph++;
      s_data  = beat_data(beat);
      if (s_valid && s_ready) beat++;
      guard++;
    end
    if (beat < abort_at) chk("load_timeout", 64'(beat), 64'(abort_at));
    tick();
    s_valid = 1'b0;
  endtask

  task automatic run_to_stop(input int unsigned n, input logic [31:0] sins, input bit pulse,
                             input logic [3:0] id);
    int unsigned c = 0, guard = 0;
    while (c < n && guard < n + 20) begin
      tick();
      guard++;
      start = 1'b0;
      instr = (cyc % 2 == 1) ? 32'h5000_007F : 32'h0000_003E;
      if (cpu_enable) begin
        c++;
        if (c == n) begin
          chk("cnt_before_stop", 64'(cycle_count), 64'(n - 1));
          instr = sins;
        end else if (pulse && c == n / 2) begin
          start = 1'b1;
        end
      end
    end
    if (c < n) chk("run_timeout", 64'(c), 64'(n));
    tick();
    instr = NOP;
    chk("en_rise", 64'(t_en), 64'(t_last_i + 1));
    chk("en_fall", 64'(cpu_enable), 64'd0);
    chk("stop_id", 64'(stop_id), 64'(id));
    chk("cycle_count", 64'(cycle_count), 64'(n));
  endtask

`ifdef MEM_BOOT_CTRL_READBACK_EN
  task automatic dump();
    int unsigned g;
    chk("done_early", 64'(done), 64'd0);
    for (int j = 0; j < 12; j++) begin
      g = 0;
      tick();
      while (!m_valid && g < 10) begin
        tick();
        g++;
      end
      chk("dump_valid", 64'(m_valid), 64'd1);
      chk("dump_data", m_data, dpat(35 + j));
      if (j == 0) begin
        for (int s = 0; s < 5; s++) begin
          tick();
          chk("stall_valid", 64'(m_valid), 64'd1);
          chk("stall_data", m_data, dpat(35));
        end
      end
      m_ready = 1'b1;
    end
    tick();
    m_ready = 1'b0;
    chk("dump_done", 64'(done), 64'd1);
  endtask
`endif

  task automatic finish_stop(input int unsigned n);
`ifdef MEM_BOOT_CTRL_READBACK_EN
    dump();
`else
    chk("done", 64'(done), 64'd1);
    chk("m_valid_tied", 64'(m_valid), 64'd0);
`endif
    for (int h = 0; h < 3; h++) tick();
    chk("done_hold", {62'd0, done, cpu_enable}, 64'd2);
    chk("cycles_hold", 64'(cycle_count), 64'(n));
  endtask

  task automatic load_checks(input int unsigned div);
    chk("d_count", 64'(d_idx), 64'(DW));
    chk("last_d", last_d, 64'h1FF8);
    chk("i_count", 64'(i_idx), 64'(IW));
    chk("last_i", last_i, 64'h7FC);
    if (div == 1) chk("d2i_gap", 64'(t_first_i - t_last_d), 64'd1);
  endtask

  initial begin
    vecs[0] = '{div: 1, n: 100, stop_instr: 32'h5000_007E, id: 4'd5,  pulse: 1'b0};
    vecs[1] = '{div: 3, n: 37,  stop_instr: 32'hA000_0FFE, id: 4'd10, pulse: 1'b1};
    vecs[2] = '{div: 1, n: 1,   stop_instr: 32'hF000_007E, id: 4'd15, pulse: 1'b0};

    #2 arst = 1'b1;
    tick();
    tick();
    rst_checks();
    arst = 1'b0;
    tick();

    for (int v = 0; v < 3; v++) begin
      load_image(vecs[v].div, NB);
      load_checks(vecs[v].div);
      run_to_stop(vecs[v].n, vecs[v].stop_instr, vecs[v].pulse, vecs[v].id);
      finish_stop(vecs[v].n);
    end

    // Abort partway through the imem phase, then restart from scratch.
    load_image(1, DW + 100);
    arst = 1'b1;
    #1;
    rst_checks();
    tick();
    arst = 1'b0;
    tick();
    chk("idle_after_rst", {62'd0, s_ready, done}, 64'd0);
    load_image(1, NB);
    load_checks(1);
    run_to_stop(5, 32'h3000_007E, 1'b0, 4'd3);
    finish_stop(5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
